// File: rtl/ipv4_pkg.sv
// ipv4_pkg: state encoding, IPv4 header constants and the checksum fold helper
package ipv4_pkg;
  typedef enum logic [2:0] {IDLE, CSUM, HDR0, HDR1, HDR2, PAYLOAD, TAIL} state_e;
  localparam logic [3:0]  IPV4_VERSION   = 4'd4;
  localparam logic [3:0]  IPV4_MIN_IHL   = 4'd5;
  localparam logic [15:0] IPV4_HDR_BYTES = 16'd20;
  localparam logic [15:0] IPV4_FLAGS_DF  = 16'h4000;
  function automatic logic [15:0] ipv4_csum_fold(input logic [19:0] sum);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    s2 = s1[15:0] + {15'd0, s1[16]};
    return s2;
  endfunction
endpackage

// File: rtl/ipv4_checksum.sv
// ipv4_checksum: one's-complement sum of ten 16-bit header words, result registered when en is high
module ipv4_checksum
  import ipv4_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [159:0] words,
  output logic [15:0]  csum
);
  logic [19:0] sum;
  logic [15:0] csum_q, csum_d;
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) sum = sum + {4'd0, words[i*16 +: 16]};
    csum_d = en ? ~ipv4_csum_fold(sum) : csum_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum_q <= '0;
    else csum_q <= csum_d;
  assign csum = csum_q;
endmodule

// File: rtl/ipv4_header_builder.sv
// ipv4_header_builder: prepends a 20-byte IPv4 header to an L4 payload stream.
// Define IPV4_HDR_CSUM_EN to compute the header checksum (adds one CSUM cycle).
module ipv4_header_builder
  import ipv4_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter logic [7:0]  TTL        = 8'd64,
  parameter logic [7:0]  TOS        = 8'd0,
  parameter logic [15:0] ID_INIT    = 16'd0,
  localparam int         IW         = $clog2(DATA_WIDTH/8+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_valid_in,
  output logic                  hdr_ready_out,
  input  logic [31:0]           src_ip,
  input  logic [31:0]           dst_ip,
  input  logic [7:0]            protocol,
  input  logic [15:0]           payload_len,
  input  logic [DATA_WIDTH-1:0] tdata_in,
  input  logic [IW-1:0]         idx_in,
  input  logic                  data_valid_in,
  input  logic                  last_flag_in,
  output logic                  payload_ready_out,
  output logic [DATA_WIDTH-1:0] tdata_out,
  output logic [IW-1:0]         idx_out,
  output logic                  data_valid_out,
  output logic                  last_flag_out,
  input  logic                  ready_in
);
`ifdef IPV4_HDR_CSUM_EN
  localparam state_e FIRST = CSUM;
`else
  localparam state_e FIRST = HDR0;
`endif
  state_e                state_q, state_d;
  logic [31:0]           src_q, src_d, dst_q, dst_d, res_q, res_d;
  logic [7:0]            proto_q, proto_d;
  logic [15:0]           len_q, len_d, id_q, id_d;
  logic [IW-1:0]         tail_q, tail_d, idx_q, idx_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  valid_q, valid_d, last_q, last_d, hdr_rdy_q, hdr_rdy_d;
  logic                  adv, hs, zero, take, fin, split;
  logic [15:0]           tot_len, csum;
  logic [63:0]           beat0, beat1;
  logic [31:0]           hdr_tail;
  assign adv               = !valid_q || ready_in;
  assign hdr_ready_out     = hdr_rdy_q;
  assign hs                = hdr_valid_in && hdr_ready_out;
  assign zero              = state_q == HDR2 && len_q == '0;
  assign payload_ready_out = ((state_q == HDR2 && !zero) || state_q == PAYLOAD) && adv;
  assign take              = payload_ready_out && data_valid_in;
  assign fin               = take && last_flag_in && idx_in <= IW'(4);
  assign split             = take && last_flag_in && idx_in > IW'(4);
  assign tot_len           = len_q + IPV4_HDR_BYTES;
  assign beat0    = {IPV4_FLAGS_DF[7:0], IPV4_FLAGS_DF[15:8], id_q[7:0], id_q[15:8],
                     tot_len[7:0], tot_len[15:8], TOS, IPV4_VERSION, IPV4_MIN_IHL};
  assign beat1    = {src_q[7:0], src_q[15:8], src_q[23:16], src_q[31:24],
                     csum[7:0], csum[15:8], proto_q, TTL};
  assign hdr_tail = {dst_q[7:0], dst_q[15:8], dst_q[23:16], dst_q[31:24]};
`ifdef IPV4_HDR_CSUM_EN
  ipv4_checksum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == CSUM),
    .words ({IPV4_VERSION, IPV4_MIN_IHL, TOS, tot_len, id_q, IPV4_FLAGS_DF,
             TTL, proto_q, 16'd0, src_q, dst_q}),
    .csum  (csum)
  );
`else
  assign csum = 16'h0000;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      proto_q   <= '0;
      len_q     <= '0;
      id_q      <= ID_INIT;
      res_q     <= '0;
      tail_q    <= '0;
      tdata_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      hdr_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      proto_q   <= proto_d;
      len_q     <= len_d;
      id_q      <= id_d;
      res_q     <= res_d;
      tail_q    <= tail_d;
      tdata_q   <= tdata_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      hdr_rdy_q <= hdr_rdy_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          state_d = hs ? FIRST : IDLE;
      CSUM:          state_d = HDR0;
      HDR0:          state_d = adv ? HDR1 : HDR0;
      HDR1:          state_d = adv ? HDR2 : HDR1;
      HDR2, PAYLOAD: state_d = (zero && adv) || fin ? IDLE : split ? TAIL : take ? PAYLOAD : state_q;
      TAIL:          state_d = adv ? IDLE : TAIL;
      default:       state_d = IDLE;
    endcase
  end
  // Output stage: header beats, then payload shifted up by four lanes behind the residual
  always_comb begin
    hdr_rdy_d = state_d == IDLE;
    id_d      = state_q == HDR2 && state_d != HDR2 ? id_q + 16'd1 : id_q;
    src_d     = hs ? src_ip : src_q;
    dst_d     = hs ? dst_ip : dst_q;
    proto_d   = hs ? protocol : proto_q;
    len_d     = hs ? payload_len : len_q;
    res_d     = take ? tdata_in[63:32] : res_q;
    tail_d    = split ? idx_in - IW'(4) : tail_q;
    valid_d   = adv ? (state_q inside {HDR0, HDR1, TAIL}) || zero || take : valid_q;
    last_d    = adv ? state_q == TAIL || zero || fin : last_q;
    idx_d     = !adv ? idx_q : state_q == TAIL ? tail_q : zero ? IW'(4) :
                fin ? idx_in + IW'(4) : IW'(8);
    tdata_d   = !adv ? tdata_q : state_q == HDR0 ? beat0 : state_q == HDR1 ? beat1 :
                state_q == TAIL ? {32'd0, res_q} :
                state_q == HDR2 ? {zero ? 32'd0 : tdata_in[31:0], hdr_tail} :
                {tdata_in[31:0], res_q};
  end
  assign tdata_out      = tdata_q;
  assign idx_out        = idx_q;
  assign data_valid_out = valid_q;
  assign last_flag_out  = last_q;
endmodule
